// File: rtl/uart_frame_tx.sv
// RS-485 burst frame transmitter: direction-line sequencing around BYTES words read from a memory window.
// Define UART_FRAME_TX_PARITY_EN to append a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_frame_tx #(
  parameter int BYTES      = 14,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 1,
  parameter int LSB_FIRST  = 1,
  parameter int DIR_LEAD   = 15,
  parameter int DIR_LAG    = 15,
  parameter int ADDR_W     = 10,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RQ,
  input  logic [7:0]        cycle,
  input  logic [7:0]        data,
  output logic [ADDR_W-1:0] addr,
  output logic              tx,
  output logic              dirTX,
  output logic              dirRX,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  // Request protocol: a level on RQ starts exactly one frame; done pulses once when the
  // bus is released, and RQ must go low before another frame can start.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIRON  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DIROFF = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

`ifdef UART_FRAME_TX_PARITY_EN
  localparam int         P       = 1;
  localparam logic [4:0] BC_PAR  = 5'(DATA_BITS + 1);
  localparam logic       PAR_ODD = (PARITY_ODD != 0);
`else
  localparam int         P       = 0 * PARITY_ODD;
`endif
  localparam logic [4:0] BC_DLAST  = 5'(DATA_BITS);
  localparam logic [4:0] BC_STOP1  = 5'(DATA_BITS + P + 1);
  localparam logic [4:0] BC_LAST   = 5'(DATA_BITS + P + STOP_BITS + GAP_BITS);
  localparam logic [5:0] DLY_LEAD  = 6'(DIR_LEAD);
  localparam logic [5:0] DLY_LEAD2 = 6'(2 * DIR_LEAD);
  localparam logic [5:0] DLY_LAG   = 6'(DIR_LAG);
  localparam logic [5:0] DLY_LAG2  = 6'(2 * DIR_LAG);
  localparam logic [7:0] IDX_LAST  = 8'(BYTES);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  logic              r_rq_m, r_rq_s;
  state_t            r_state, w_state_nxt;
  logic [5:0]        r_dly, w_dly_nxt;
  logic [4:0]        r_bc, w_bc_nxt;
  logic [7:0]        r_idx, w_idx_nxt;
  logic [7:0]        r_cyc, w_cyc_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_dirtx, w_dirtx_nxt;
  logic              r_dirrx, w_dirrx_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [2:0]        w_bsel;

  // RQ arrives from another clock domain; the synchroniser is deliberately left unreset.
  always_ff @(posedge clk) begin
    r_rq_m <= RQ;
    r_rq_s <= r_rq_m;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_bc_nxt    = r_bc;
    w_idx_nxt   = r_idx;
    w_cyc_nxt   = r_cyc;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_dirtx_nxt = r_dirtx;
    w_dirrx_nxt = r_dirrx;
    w_done_nxt  = 1'b0;
    if (LSB_FIRST != 0) w_bsel = 3'(r_bc - 5'd1);
    else                w_bsel = 3'(BC_DLAST - r_bc);

    case (r_state)
      S_IDLE: begin
        if (r_rq_s) begin
          w_state_nxt = S_DIRON;
          w_cyc_nxt   = cycle;
          w_idx_nxt   = 8'd0;
          w_dly_nxt   = 6'd0;
          w_bc_nxt    = 5'd0;
        end
      end
      S_DIRON: begin
        w_dly_nxt = r_dly + 6'd1;
        if (r_dly == 6'd0)     w_dirrx_nxt = 1'b1;
        if (r_dly == DLY_LEAD) w_dirtx_nxt = 1'b1;
        if (r_dly == DLY_LEAD2) begin
          w_state_nxt = S_SHIFT;
          w_dly_nxt   = 6'd0;
          w_bc_nxt    = 5'd0;
        end
      end
      S_SHIFT: begin
        w_bc_nxt = r_bc + 5'd1;
        if (r_bc == 5'd0) begin
          w_tx_nxt    = 1'b0;
          w_shift_nxt = data & DATA_MASK;
        end else if (r_bc <= BC_DLAST) begin
          w_tx_nxt = r_shift[w_bsel];
        end
`ifdef UART_FRAME_TX_PARITY_EN
        else if (r_bc == BC_PAR) begin
          w_tx_nxt = (^r_shift) ^ PAR_ODD;
        end
`endif
        if (r_bc == BC_STOP1) w_idx_nxt = r_idx + 8'd1;
        // With a single stop bit and no gap the increment and the slot end coincide,
        // so the end-of-frame test looks at the already-updated index.
        if (r_bc == BC_LAST) begin
          w_bc_nxt = 5'd0;
          if (w_idx_nxt == IDX_LAST) begin
            w_state_nxt = S_DIROFF;
            w_idx_nxt   = 8'd0;
            w_dly_nxt   = 6'd0;
          end
        end
      end
      S_DIROFF: begin
        w_dly_nxt = r_dly + 6'd1;
        if (r_dly == DLY_LAG) w_dirtx_nxt = 1'b0;
        if (r_dly == DLY_LAG2) begin
          w_dirrx_nxt = 1'b0;
          w_state_nxt = S_HOLD;
          w_done_nxt  = 1'b1;
          w_dly_nxt   = 6'd0;
        end
      end
      S_HOLD: begin
        if (!r_rq_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Address follows the index in the same edge, giving the memory the whole stop/gap time.
    w_addr_nxt = ADDR_W'(32'(w_idx_nxt) + 32'(w_cyc_nxt) * 32'(BYTES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dly   <= 6'd0;
      r_bc    <= 5'd0;
      r_idx   <= 8'd0;
      r_cyc   <= 8'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_dirtx <= 1'b0;
      r_dirrx <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_bc    <= w_bc_nxt;
      r_idx   <= w_idx_nxt;
      r_cyc   <= w_cyc_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_dirtx <= w_dirtx_nxt;
      r_dirrx <= w_dirrx_nxt;
      r_done  <= w_done_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign addr        = r_addr;
  assign tx          = r_tx;
  assign dirTX       = r_dirtx;
  assign dirRX       = r_dirrx;
  assign done        = r_done;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised RS-485 frame transmitter, next generation of the telemetry burst UART. On a request it asserts the bus direction lines, streams `BYTES` words from an external synchronous memory window selected by `cycle`, then releases the bus. Word width, stop bits, inter-word gap, bit order and direction-line guard times are configurable. It sits between the frame ROM/RAM and the RS-485 driver and runs on the baud clock.

## Interface
- `BYTES`, 14: words per frame, 1..255
- `DATA_BITS`, 8: bits per word, 5..8
- `STOP_BITS`, 1: stop bits, 1 or 2
- `GAP_BITS`, 1: extra idle-high bit periods after the stop bits, 0..7
- `LSB_FIRST`, 1: 1 sends `data[0]` first; 0 sends `data[DATA_BITS-1]` first
- `DIR_LEAD`, 15: clocks from `dirRX` to `dirTX`, and again from `dirTX` to the start bit; 1..31
- `DIR_LAG`, 15: clocks from the last stop or gap bit to `dirTX` low, and again to `dirRX` low; 1..31
- `ADDR_W`, 10: address width
- `PARITY_ODD`, 0: parity sense, used only with the parity macro
- `clk` in 1: baud clock; one bit period per clock
- `reset` in 1: asynchronous, active-low global reset
- `RQ` in 1: transfer request from another clock domain; level-sensitive
- `cycle` in 8: frame window index
- `data` in 8: memory read data; bits above `DATA_BITS-1` are ignored
- `addr` out `ADDR_W`: memory address
- `tx` out 1: serial line, idle high
- `dirTX` out 1: RS-485 driver enable
- `dirRX` out 1: RS-485 receiver disable
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-clock pulse on entry to HOLD

## Operation
- `RQ` passes through a 2-flop synchroniser (`rq_s`). These flops are not reset.
- States:
  - IDLE → DIRON when `rq_s`=1. On this transition `cycle` is latched into `cyc_l` and the word index `idx` is set to 0.
  - DIRON:
    - counter `dly` counts from 0
    - `dirRX`←1 at `dly`=0
    - `dirTX`←1 at `dly`=DIR_LEAD
    - → SHIFT at `dly`=2·DIR_LEAD
  - SHIFT: bit counter `bc` runs over each word slot:
    - start bit 0; the word is captured from `data` into the shift register in this cycle
    - DATA_BITS data bits in the order set by `LSB_FIRST`
    - optional parity bit
    - STOP_BITS bits of 1, then GAP_BITS bits of 1
    - `idx` increments on the first stop-bit cycle
    - After the last slot bit: if `idx`==BYTES → DIROFF with `idx`←0, `dly`←0; otherwise the next start bit follows immediately.
  - DIROFF:
    - `dirTX`←0 at `dly`=DIR_LAG
    - `dirRX`←0 at `dly`=2·DIR_LAG
    - then → HOLD
  - HOLD: `done` pulses for one clock on entry; → IDLE when `rq_s`=0.
- Address: `addr` = `idx + cyc_l*BYTES`, computed at full width and truncated to ADDR_W, so it wraps modulo 2^ADDR_W. It is registered from `idx`/`cyc_l`, so `cycle` changes mid-frame have no effect.
- Memory contract: `data` must be valid within STOP_BITS+GAP_BITS−1 clocks of an `addr` change.
  - With GAP_BITS=0 and STOP_BITS=1 this means the source must be combinational.
  - Word 0 has the whole DIRON period to settle.
- `RQ` falling during DIRON, SHIFT or DIROFF is ignored; the frame always completes.
- `RQ` still high in HOLD keeps the block in HOLD, so there is exactly one frame per request.

## Timing
- Reset values: `tx`=1, `dirTX`=0, `dirRX`=0, `busy`=0, `done`=0, `addr`=0, state IDLE, all counters 0.
- Reset is asynchronous at any point, including mid-word: `tx` goes high and both direction lines go low immediately, with no partial stop bit.
- `RQ` high before edge k → DIRON from edge k+2; `dirRX` high after edge k+3.
- `dirRX` rise to start bit: 2·DIR_LEAD+1 clocks.
- Slot length = 1 + DATA_BITS + P + STOP_BITS + GAP_BITS clocks, where P is 1 with parity and 0 without.
- Last gap bit to `dirRX` low: 2·DIR_LAG+1 clocks.

## Configuration
- `UART_FRAME_TX_PARITY_EN` defined:
  - one parity bit follows the data bits
  - even parity, i.e. XOR of the data bits, when PARITY_ODD=0
  - its inverse when PARITY_ODD=1
- Not defined: no parity bit, P=0, and PARITY_ODD is ignored.

## Test plan
- Defaults, BYTES=3, `cycle`=2, memory holds 0xA5 at every address → `addr` 6,7,8; each word on `tx` is 0,1,0,1,0,0,1,0,1,1 then a gap bit of 1; `done` pulses once.
- LSB_FIRST=0, DATA_BITS=7, `data`=0x41 → `tx` 0,1,0,0,0,0,0,1,1.
- With `UART_FRAME_TX_PARITY_EN`, PARITY_ODD=0, `data`=0xA5 → parity bit 0; with `data`=0x01 → parity bit 1.
- `RQ` held high through HOLD for 100 clocks → a single frame only; after `RQ` drops for 3 clocks and rises again, a second frame starts.
- `reset` asserted on the 4th data bit → `tx`=1 and `dirTX`=`dirRX`=0 within the same cycle; after release the block is in IDLE.
- `cycle`=255, BYTES=14, ADDR_W=10 → `addr` starts at 3570 mod 1024 = 498, and holds its sequence when `cycle` changes mid-frame.
